// File: rtl/ro_puf_pkg.sv
// ro_puf_pkg: shared state type, output decode, width helper and default
// parameter values for the multi-bit RO-PUF response sequencer.
package ro_puf_pkg;

    localparam int unsigned DEF_REF_WIDTH     = 8;
    localparam int unsigned DEF_NUM_BITS      = 64;
    localparam int unsigned DEF_SETTLE_CYCLES = 2;
    localparam int unsigned DEF_REPEATS       = 3;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LOAD   = 3'd1,
        RST    = 3'd2,
        MEAS   = 3'd3,
        HOLD   = 3'd4,
        SAMPLE = 3'd5,
        SHIFT  = 3'd6,
        DONE   = 3'd7
    } state_t;

    // Control strobes that are pure functions of the state.
    typedef struct packed {
        logic busy;
        logic done;
        logic lfsr_dv;
        logic lfsr_en;
        logic ro_en;
        logic count_en;
        logic ref_en;
        logic count_reset;
        logic sr_en;
    } ctrl_t;

    // Counter width for values 0..n-1, never narrower than one bit.
    function automatic int unsigned clog2w(input int unsigned n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

    // Moore decode: the control word each state presents while it is current.
    function automatic ctrl_t decode(input state_t s);
        ctrl_t c;
        c = '0;
        case (s)
            LOAD: begin
                c.busy    = 1'b1;
                c.lfsr_dv = 1'b1;
            end
            RST: begin
                c.busy        = 1'b1;
                c.count_reset = 1'b1;
            end
            MEAS: begin
                c.busy     = 1'b1;
                c.ro_en    = 1'b1;
                c.count_en = 1'b1;
                c.ref_en   = 1'b1;
            end
            HOLD, SAMPLE: begin
                c.busy = 1'b1;
            end
            SHIFT: begin
                c.busy    = 1'b1;
                c.sr_en   = 1'b1;
                c.lfsr_en = 1'b1;
            end
            DONE: begin
                c.done = 1'b1;
            end
            default: begin
                c = '0;
            end
        endcase
        return c;
    endfunction

endpackage

// File: rtl/ro_puf_vote.sv
// ro_puf_vote: counts comparator ones across the repeats of one challenge
// and gives the majority decision including the measurement being sampled
// this cycle, so the verdict is ready on the same edge the last repeat is
// captured. Only instantiated when ROPUF_MAJORITY_VOTE_EN is defined.
module ro_puf_vote
    import ro_puf_pkg::*;
#(
    parameter int unsigned REPEATS = DEF_REPEATS
)
(
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_clear,
    input  logic i_sample,
    input  logic i_cmp_bit,
    output logic o_vote
);

    localparam int unsigned ONES_W = clog2w(REPEATS + 1);

    logic [ONES_W-1:0] r_ones;
    logic [ONES_W:0]   w_total;

    // Ones seen so far plus the comparator bit being sampled now.
    assign w_total = {1'b0, r_ones} + {{ONES_W{1'b0}}, i_cmp_bit};
    assign o_vote  = (32'(w_total) > (REPEATS / 2));

    // Ones accumulator; cleared once the bit has been shifted out or the run ends.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_ones <= '0;
        end else if (i_clear) begin
            r_ones <= '0;
        end else if (i_sample) begin
            r_ones <= r_ones + ONES_W'(i_cmp_bit);
        end
    end

endmodule

// File: rtl/ro_puf_seq_ctrl.sv
// ro_puf_seq_ctrl: sequences a NUM_BITS RO-PUF response, one ring-oscillator
// pair comparison per challenge bit, with a programmable reference window,
// abort and busy/bit-index status.
// Build option: define ROPUF_MAJORITY_VOTE_EN to measure each challenge
// REPEATS times and shift out the majority result.
//
// state  | meaning
// IDLE   | waiting for start, all outputs low
// LOAD   | load LFSR seed (lfsr_dv)
// RST    | hold counters in reset for SETTLE_CYCLES
// MEAS   | oscillators and counters running until refcount hits the window
// HOLD   | enables dropped, counters frozen while the comparator settles
// SAMPLE | capture cmp_bit (or vote)
// SHIFT  | shift response bit out, step LFSR
// DONE   | one-cycle completion pulse
module ro_puf_seq_ctrl
    import ro_puf_pkg::*;
#(
    parameter int unsigned REF_WIDTH     = DEF_REF_WIDTH,
    parameter int unsigned NUM_BITS      = DEF_NUM_BITS,
    parameter int unsigned SETTLE_CYCLES = DEF_SETTLE_CYCLES,
    parameter int unsigned REPEATS       = DEF_REPEATS
)
(
    input  logic                          i_clk,
    input  logic                          i_rst_n,
    input  logic                          i_start,
    input  logic                          i_abort,
    input  logic [REF_WIDTH-1:0]          i_window_len,
    input  logic [REF_WIDTH-1:0]          i_refcount,
    input  logic                          i_cmp_bit,
    output logic                          o_busy,
    output logic                          o_done,
    output logic                          o_lfsr_dv,
    output logic                          o_lfsr_en,
    output logic                          o_ro_en,
    output logic                          o_count_en,
    output logic                          o_ref_en,
    output logic                          o_count_reset,
    output logic                          o_sr_en,
    output logic                          o_sr_bit,
    output logic [clog2w(NUM_BITS)-1:0]   o_bit_idx
);

    localparam int unsigned IDX_W = clog2w(NUM_BITS);
    localparam int unsigned SET_W = clog2w(SETTLE_CYCLES);
    localparam int unsigned REP_W = clog2w(REPEATS);
`ifdef ROPUF_MAJORITY_VOTE_EN
    localparam int unsigned MEAS_PER_BIT = REPEATS;
`else
    localparam int unsigned MEAS_PER_BIT = 1;
`endif

    localparam logic [IDX_W-1:0] LAST_BIT    = IDX_W'(NUM_BITS - 1);
    localparam logic [SET_W-1:0] SETTLE_LOAD = SET_W'(SETTLE_CYCLES - 1);
    localparam logic [REP_W-1:0] LAST_REP    = REP_W'(MEAS_PER_BIT - 1);

    state_t               r_state;
    state_t               w_next;
    ctrl_t                r_ctrl;
    logic                 r_sr_bit;
    logic [REF_WIDTH-1:0] r_win;
    logic [SET_W-1:0]     r_settle;
    logic [IDX_W-1:0]     r_bit_idx;
    logic [REP_W-1:0]     r_rep;
    logic                 w_meas_bit;

`ifdef ROPUF_MAJORITY_VOTE_EN
    logic w_vote;
    logic w_vote_clear;
    logic w_vote_sample;

    // The tally restarts after every shifted bit and whenever the run is left.
    assign w_vote_clear  = (r_state == SHIFT) || (w_next == IDLE);
    assign w_vote_sample = (r_state == SAMPLE);

    ro_puf_vote #(
        .REPEATS (REPEATS)
    ) u_vote (
        .i_clk     (i_clk),
        .i_rst_n   (i_rst_n),
        .i_clear   (w_vote_clear),
        .i_sample  (w_vote_sample),
        .i_cmp_bit (i_cmp_bit),
        .o_vote    (w_vote)
    );

    assign w_meas_bit = w_vote;
`else
    assign w_meas_bit = i_cmp_bit;
`endif

    // Next-state selection; abort overrides everything and also blocks start in IDLE.
    always_comb begin
        w_next = r_state;
        unique case (r_state)
            IDLE:    if (i_start) w_next = LOAD;
            LOAD:    w_next = RST;
            RST:     if (r_settle == '0) w_next = MEAS;
            MEAS:    if (i_refcount == r_win) w_next = HOLD;
            HOLD:    w_next = SAMPLE;
            SAMPLE:  w_next = (r_rep == LAST_REP) ? SHIFT : RST;
            SHIFT:   w_next = (r_bit_idx == LAST_BIT) ? DONE : RST;
            DONE:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
        if (i_abort) begin
            w_next = IDLE;
        end
    end

    // State, timers and registered outputs decoded from the state being entered.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state   <= IDLE;
            r_ctrl    <= '0;
            r_sr_bit  <= 1'b0;
            r_win     <= '0;
            r_settle  <= '0;
            r_bit_idx <= '0;
            r_rep     <= '0;
        end else begin
            r_state  <= w_next;
            r_ctrl   <= decode(w_next);
            r_sr_bit <= (w_next == SHIFT) ? w_meas_bit : 1'b0;

            // A zero window would never let MEAS see a match after counting starts.
            if (r_state == IDLE && w_next == LOAD) begin
                r_win <= (i_window_len == '0) ? REF_WIDTH'(1) : i_window_len;
            end

            if (w_next == RST && r_state != RST) begin
                r_settle <= SETTLE_LOAD;
            end else if (w_next == IDLE) begin
                r_settle <= '0;
            end else if (r_state == RST && r_settle != '0) begin
                r_settle <= r_settle - SET_W'(1);
            end

            if (w_next == IDLE) begin
                r_bit_idx <= '0;
            end else if (r_state == SHIFT && w_next == RST) begin
                r_bit_idx <= r_bit_idx + IDX_W'(1);
            end

            if (w_next == IDLE || r_state == SHIFT) begin
                r_rep <= '0;
            end else if (r_state == SAMPLE && w_next == RST) begin
                r_rep <= r_rep + REP_W'(1);
            end
        end
    end

    // Output ports straight from registers.
    assign o_busy        = r_ctrl.busy;
    assign o_done        = r_ctrl.done;
    assign o_lfsr_dv     = r_ctrl.lfsr_dv;
    assign o_lfsr_en     = r_ctrl.lfsr_en;
    assign o_ro_en       = r_ctrl.ro_en;
    assign o_count_en    = r_ctrl.count_en;
    assign o_ref_en      = r_ctrl.ref_en;
    assign o_count_reset = r_ctrl.count_reset;
    assign o_sr_en       = r_ctrl.sr_en;
    assign o_sr_bit      = r_sr_bit;
    assign o_bit_idx     = r_bit_idx;

endmodule

// File: tb/tb_ro_puf_seq_ctrl.sv
// tb_ro_puf_seq_ctrl: randomized bench for ro_puf_seq_ctrl with an external
// reference-counter model and a run-level reference model (latencies and
// response bits computed from the timing rules, majority computed by counting).
module tb_ro_puf_seq_ctrl;

    localparam int NB  = 4;
    localparam int S   = 2;
    localparam int RW  = 8;
    localparam int REP = 3;
`ifdef ROPUF_MAJORITY_VOTE_EN
    localparam int MP   = REP;
    localparam bit VOTE = 1'b1;
`else
    localparam int MP   = 1;
    localparam bit VOTE = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic          abort = 1'b0;
    logic          cmp_bit = 1'b0;
    logic [RW-1:0] window_len = '0;
    logic [RW-1:0] refcount = '0;
    logic          busy, done, lfsr_dv, lfsr_en, ro_en, count_en, ref_en;
    logic          count_reset, sr_en, sr_bit;
    logic [1:0]    bit_idx;

    always #5 clk = ~clk;

    ro_puf_seq_ctrl #(
        .REF_WIDTH     (RW),
        .NUM_BITS      (NB),
        .SETTLE_CYCLES (S),
        .REPEATS       (REP)
    ) dut (
        .i_clk         (clk),
        .i_rst_n       (rst_n),
        .i_start       (start),
        .i_abort       (abort),
        .i_window_len  (window_len),
        .i_refcount    (refcount),
        .i_cmp_bit     (cmp_bit),
        .o_busy        (busy),
        .o_done        (done),
        .o_lfsr_dv     (lfsr_dv),
        .o_lfsr_en     (lfsr_en),
        .o_ro_en       (ro_en),
        .o_count_en    (count_en),
        .o_ref_en      (ref_en),
        .o_count_reset (count_reset),
        .o_sr_en       (sr_en),
        .o_sr_bit      (sr_bit),
        .o_bit_idx     (bit_idx)
    );

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string tag, input longint got, input longint exp);
        n_chk++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    endtask

    // Bench-side state: ref counter, cmp pattern driver and observations.
    int cyc = 0;
    int m_ref = 0;
    bit p_cr = 1'b0;
    bit p_re = 1'b0;
    int meas_idx = -1;
    int meas_len = 0;
    bit pat[$];
    int meas_lens[$];
    bit got_bits[$];
    int got_idx[$];
    int n_dv, n_en, n_done, n_busy, done_cyc, dv_cyc;

    function automatic logic [11:0] outs();
        return {busy, done, lfsr_dv, lfsr_en, ro_en, count_en, ref_en,
                count_reset, sr_en, sr_bit, bit_idx};
    endfunction

    function automatic int per_bit(input int w);
        return VOTE ? REP * (S + w + 3) + 1 : S + w + 4;
    endfunction

    task automatic clear_stats();
        meas_lens.delete();
        got_bits.delete();
        got_idx.delete();
        meas_idx = -1;
        meas_len = 0;
        n_dv = 0; n_en = 0; n_done = 0; n_busy = 0;
        done_cyc = -1000; dv_cyc = -1000;
    endtask

    task automatic fill_pat();
        pat.delete();
        for (int i = 0; i < NB * MP; i++) pat.push_back(1'($urandom_range(0, 1)));
    endtask

    // One clock: observe just after the edge, then update the external models.
    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        if (p_cr) m_ref = 0;
        else if (p_re) m_ref = m_ref + 1;
        refcount = RW'(m_ref);
        if (count_reset && !p_cr) begin
            meas_idx++;
            cmp_bit = (meas_idx < pat.size()) ? pat[meas_idx] : 1'b0;
        end
        if (ref_en) meas_len++;
        else if (p_re) begin
            meas_lens.push_back(meas_len);
            meas_len = 0;
        end
        p_cr = count_reset;
        p_re = ref_en;
        if (sr_en) begin
            got_bits.push_back(sr_bit);
            got_idx.push_back(int'(bit_idx));
        end
        if (lfsr_dv) begin n_dv++; dv_cyc = cyc; end
        if (lfsr_en) n_en++;
        if (busy) n_busy++;
        if (done) begin n_done++; done_cyc = cyc; end
    endtask

    // Full run from the current pattern, checked against the run model.
    task automatic run(input int wl, input bit chg_win, input bit extra_start, input string tag);
        int w_eff, exp_done, t0, ones;
        w_eff    = (wl == 0) ? 1 : wl;
        exp_done = 2 + NB * per_bit(w_eff);
        clear_stats();
        window_len = RW'(wl);
        start = 1'b1;
        t0 = cyc;
        tick();
        start = 1'b0;
        if (chg_win) window_len = RW'($urandom_range(0, 255));
        while (cyc < t0 + exp_done + 3) begin
            tick();
            start = extra_start && ((cyc - t0 == 5) || (cyc - t0 == 30));
        end
        start = 1'b0;
        chk({tag, "_done_cyc"}, done_cyc - t0, exp_done);
        chk({tag, "_n_done"}, n_done, 1);
        chk({tag, "_n_lfsr_dv"}, n_dv, 1);
        chk({tag, "_n_lfsr_en"}, n_en, NB);
        chk({tag, "_n_sr_en"}, got_bits.size(), NB);
        chk({tag, "_busy_cycles"}, n_busy, exp_done - 1);
        chk({tag, "_n_meas"}, meas_lens.size(), NB * MP);
        foreach (meas_lens[i]) chk({tag, "_meas_len"}, meas_lens[i], w_eff + 1);
        for (int b = 0; b < NB; b++) begin
            ones = 0;
            for (int r = 0; r < MP; r++) ones += int'(pat[b * MP + r]);
            if (b < got_bits.size()) begin
                chk($sformatf("%s_sr_bit%0d", tag, b), got_bits[b], (2 * ones > MP) ? 1 : 0);
                chk($sformatf("%s_bit_idx%0d", tag, b), got_idx[b], b);
            end
        end
        chk({tag, "_idle_outs"}, outs(), 0);
    endtask

    initial begin
        int k, t0;

        // Reset state, asynchronously applied from time 0.
        #2;
        chk("reset_outs", outs(), 0);
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        chk("idle_outs", outs(), 0);

        // abort and start together in IDLE: abort wins.
        clear_stats();
        start = 1'b1;
        abort = 1'b1;
        tick();
        tick();
        start = 1'b0;
        abort = 1'b0;
        tick();
        chk("idle_abort_start_dv", n_dv, 0);
        chk("idle_abort_start_busy", n_busy, 0);

        // Basic run with a fixed comparator pattern.
        pat.delete();
`ifdef ROPUF_MAJORITY_VOTE_EN
        pat = {1'b1, 1'b0, 1'b1,  1'b0, 1'b0, 1'b1,  1'b1, 1'b1, 1'b0,  1'b0, 1'b1, 1'b1};
`else
        pat = {1'b1, 1'b0, 1'b1, 1'b1};
`endif
        run(10, 1'b0, 1'b0, "basic");

        // Window boundaries.
        fill_pat();
        run(0, 1'b0, 1'b0, "win0");
        fill_pat();
        run(255, 1'b0, 1'b0, "win255");

        // Window change mid-run and start pulses while busy.
        fill_pat();
        run(12, 1'b1, 1'b1, "busy_start");

        // Random runs.
        for (int i = 0; i < 3; i++) begin
            fill_pat();
            run($urandom_range(0, 20), 1'b1, 1'b0, $sformatf("rand%0d", i));
        end

        // Abort during MEAS of bit 2.
        fill_pat();
        clear_stats();
        window_len = 8'd8;
        start = 1'b1;
        tick();
        start = 1'b0;
        k = 0;
        while (!(ref_en && bit_idx == 2'd2) && k < 2000) begin
            tick();
            k++;
        end
        chk("abort_reached_meas2", (k < 2000) ? 1 : 0, 1);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("abort_outs", outs(), 0);
        repeat (100) tick();
        chk("abort_no_done", n_done, 0);
        chk("abort_n_sr_en", got_bits.size(), 2);
        chk("abort_n_lfsr_en", n_en, 2);

        // Run after abort restarts from bit 0.
        fill_pat();
        run(5, 1'b0, 1'b0, "post_abort");

        // start held high: next run begins right after DONE.
        fill_pat();
        clear_stats();
        window_len = 8'd3;
        start = 1'b1;
        t0 = cyc;
        k = 0;
        while (n_dv < 2 && k < 1000) begin
            tick();
            k++;
        end
        chk("held_done_cyc", done_cyc - t0, 2 + NB * per_bit(3));
        chk("held_restart_gap", dv_cyc - done_cyc, 2);
        start = 1'b0;
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("held_abort_outs", outs(), 0);

        // Asynchronous reset during SHIFT.
        fill_pat();
        clear_stats();
        window_len = 8'd4;
        start = 1'b1;
        tick();
        start = 1'b0;
        k = 0;
        while (!(sr_en && bit_idx == 2'd1) && k < 1000) begin
            tick();
            k++;
        end
        chk("rst_reached_shift", (k < 1000) ? 1 : 0, 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst_async_outs", outs(), 0);
        tick();
        tick();
        rst_n = 1'b1;
        clear_stats();
        repeat (8) tick();
        chk("rst_no_sr_en", got_bits.size(), 0);
        chk("rst_idle_busy", n_busy, 0);
        chk("rst_idle_outs", outs(), 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/ro_puf_seq_ctrl.md
Name: ro_puf_seq_ctrl

Overview:
- Parametrised successor to the single-bit RO-PUF control FSM: sequences a full multi-bit response, one ring-oscillator pair comparison per challenge bit.
- Drives the LFSR challenge generator, RO enables, RO/reference counters and the response shift register; reads back the reference count and the counter comparator bit.
- Adds a runtime-programmable measurement window, abort, busy/bit-index status, and optional majority voting.

Parameters:
- REF_WIDTH, 8: width of refcount and windowLen.
- NUM_BITS, 64: response bits per run; at least 1.
- SETTLE_CYCLES, 2: cycles countReset is held before each measurement; at least 1.
- REPEATS, 3: measurements per bit when voting is compiled in; odd, at least 1.

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- start  in  1  run request, sampled when idle
- abort  in  1  synchronous cancel of a run
- windowLen  in  REF_WIDTH  reference cycles per measurement; latched on start
- refcount  in  REF_WIDTH  reference counter value (cleared by countReset, increments while refEN)
- cmpBit  in  1  1 when RO-A count > RO-B count
- busy  out  1  high from the cycle after start is accepted until done
- done  out  1  one-cycle pulse at run end
- lfsrDV  out  1  one-cycle pulse that loads the LFSR seed
- lfsrEN  out  1  one-cycle pulse that steps the LFSR to the next challenge
- roEN  out  1  ring-oscillator enable
- countEN  out  1  RO counter enable
- refEN  out  1  reference counter enable
- countReset  out  1  clears RO and reference counters
- srEN  out  1  one-cycle shift strobe
- srBit  out  1  response bit, valid while srEN
- bitIdx  out  clog2(NUM_BITS)  index of the bit in progress

Behaviour:
- Reset value of every output is 0; state is IDLE; internal counters are 0.
- All outputs are registered Moore decodes of state.
- windowLen = 0 is treated as 1. windowLen is latched on start; changes mid-run are ignored.
- start while busy is ignored.
- State sequence:
  - IDLE: on start=1, latch windowLen, clear bitIdx → LOAD.
  - LOAD (1 cycle): lfsrDV=1 → RST.
  - RST (SETTLE_CYCLES cycles): countReset=1; roEN/countEN/refEN=0 → MEAS.
  - MEAS: roEN=countEN=refEN=1. Exit in the cycle refcount == latched window → HOLD. With an external counter starting at 0, MEAS lasts window+1 cycles.
  - HOLD (1 cycle): all enables 0, so counters freeze for comparator settle → SAMPLE.
  - SAMPLE (1 cycle): capture cmpBit → SHIFT.
  - SHIFT (1 cycle): srEN=1, srBit=captured bit, lfsrEN=1.
    - If bitIdx == NUM_BITS-1 → DONE.
    - Otherwise bitIdx+1 → RST.
  - DONE (1 cycle): done=1, busy=0 → IDLE.
- Per-bit latency without voting: SETTLE_CYCLES + window + 4 cycles.
- Run latency: done is high in cycle 2 + NUM_BITS*(SETTLE_CYCLES+window+4), counted from the edge that samples start.
- abort (any non-IDLE state, including DONE): next state IDLE. All outputs 0, no done, no srEN. bitIdx resets to 0.
- abort and start together in IDLE: abort wins, start is ignored.
- Async reset mid-run: immediate IDLE, all outputs 0.
- bitIdx never wraps within a run; it returns to 0 only at IDLE.

Optional Feature:
- Macro: ROPUF_MAJORITY_VOTE_EN.
- Defined:
  - Each bit runs RST→MEAS→HOLD→SAMPLE REPEATS times.
  - A ones counter accumulates cmpBit.
  - SHIFT occurs only after the last repeat, with srBit = (ones > REPEATS/2). The ones counter clears after SHIFT.
  - lfsrEN pulses only in SHIFT, so all repeats use the same challenge.
  - Per-bit latency: REPEATS*(SETTLE_CYCLES+window+3)+1.
- Undefined: single measurement per bit; REPEATS is unused; no vote logic is synthesised.

Decomposition:
- Package ro_puf_pkg:
  - state enum (IDLE, LOAD, RST, MEAS, HOLD, SAMPLE, SHIFT, DONE);
  - width helper function (clog2 wrapper);
  - default-parameter constants.
- One natural sub-module, ro_puf_vote: the ones counter plus majority decision, instantiated only under ROPUF_MAJORITY_VOTE_EN.

Test Plan:
- Basic run. NUM_BITS=4, SETTLE_CYCLES=2, windowLen=10, bench ref counter model, cmpBit pattern 1,0,1,1 → srEN pulses 4 times with srBit 1,0,1,1; lfsrDV once; lfsrEN 4 times; done at cycle 66; busy low afterwards.
- Window edge. windowLen=0 → MEAS lasts 2 cycles; windowLen=255 → MEAS lasts 256 cycles, refcount wrap never reached; windowLen changed mid-run → no effect.
- Start while busy. start pulsed at cycles 5 and 30 of a run → ignored, single done. start held high → new run starts right after DONE.
- Abort. abort in MEAS of bit 2 → next cycle all outputs 0, busy 0, no done. Following start → bitIdx restarts at 0.
- Reset mid-run. rst_n low during SHIFT → outputs 0 asynchronously; after release, state is IDLE and no srEN.
- Voting (macro defined). REPEATS=3, cmpBit per repeat 1,0,1 → srBit=1; 0,0,1 → srBit=0; lfsrEN once per bit.
